seq_count_fsm: RTL and testbench

Parametrised event-counting state machine that counts qualified `seq` events modulo a run-time terminal value. It raises `dout` at the terminal count, either as a level or as a one-cycle pulse, and pulses `hit` on every wrap. It also keeps a saturating wrap counter. The block sits in the sequence-detection/control path as the general replacement for fixed four-state 1-counting FSMs.

---
 rtl/seq_count_fsm.sv | 71 +++++++
 tb/tb_seq_count_fsm.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_count_fsm.sv
// seq_count_fsm: counts qualified seq events modulo a run-time terminal value,
// with level/pulse terminal indication, wrap pulse and saturating wrap count.
module seq_count_fsm #(
  parameter int CNT_W  = 4,
  parameter int WRAP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic              seq,
  input  logic              edge_mode,
  input  logic              pulse_mode,
  input  logic [CNT_W-1:0]  term,
  output logic [CNT_W-1:0]  count,
  output logic              dout,
  output logic              hit,
  output logic [WRAP_W-1:0] wraps
);

  logic             seq_d;
  logic             ev;
  logic             at_term;
  logic             wrap;
  logic             inc;
  logic [CNT_W-1:0] nc;
  logic             nc_term;
  logic             dout_nx;

  always_comb begin
    ev      = en & (edge_mode ? (seq & ~seq_d) : seq);
    at_term = count >= term;
    wrap    = ev & at_term & ~clr;
    inc     = ev & ~at_term & ~clr;
    nc      = count;
    unique case (1'b1)
      clr:     nc = '0;
      wrap:    nc = '0;
      inc:     nc = count + CNT_W'(1);
      default: nc = count;
    endcase
    nc_term = nc >= term;
    // Pulse mode fires only on entry: from below terminal, or via a wrap.
    if (clr)
      dout_nx = ~pulse_mode & (term == '0);
    else if (pulse_mode)
      dout_nx = nc_term & (~at_term | wrap);
    else
      dout_nx = nc_term;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq_d <= 1'b0;
      count <= '0;
      dout  <= 1'b0;
      hit   <= 1'b0;
      wraps <= '0;
    end else begin
      seq_d <= seq;
      count <= nc;
      dout  <= dout_nx;
      hit   <= wrap;
      if (clr)
        wraps <= '0;
      else if (wrap && !(&wraps))
        wraps <= wraps + WRAP_W'(1);
    end
  end

endmodule

// File: tb/tb_seq_count_fsm.sv
// tb_seq_count_fsm: scenario tasks with a queue of expected outputs,
// compared one cycle after each stimulus vector is applied.
module tb_seq_count_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       clr;
  logic       seq;
  logic       edge_mode;
  logic       pulse_mode;
  logic [3:0] term;
  logic [3:0] count;
  logic       dout;
  logic       hit;
  logic [1:0] wraps;

  seq_count_fsm #(.CNT_W(4), .WRAP_W(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .clr        (clr),
    .seq        (seq),
    .edge_mode  (edge_mode),
    .pulse_mode (pulse_mode),
    .term       (term),
    .count      (count),
    .dout       (dout),
    .hit        (hit),
    .wraps      (wraps)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] c;
    logic       d;
    logic       h;
    logic [1:0] w;
  } obs_t;

  typedef struct packed {
    logic       seq;
    logic       en;
    logic       clr;
    logic       em;
    logic       pm;
    logic [3:0] term;
    obs_t       exp;
  } vec_t;

  obs_t sb[$];
  obs_t got;
  obs_t ex;
  int   nvec = 0;
  int   nmis = 0;

  function automatic vec_t mk(input int s, input int e, input int c,
                              input int em, input int pm, input int t,
                              input int ec, input int ed, input int eh,
                              input int ew);
    vec_t v;
    v.seq   = 1'(s);
    v.en    = 1'(e);
    v.clr   = 1'(c);
    v.em    = 1'(em);
    v.pm    = 1'(pm);
    v.term  = 4'(t);
    v.exp.c = 4'(ec);
    v.exp.d = 1'(ed);
    v.exp.h = 1'(eh);
    v.exp.w = 2'(ew);
    return v;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.c = count;
    o.d = dout;
    o.h = hit;
    o.w = wraps;
    return o;
  endfunction

  task automatic apply(input vec_t v);
    seq        = v.seq;
    en         = v.en;
    clr        = v.clr;
    edge_mode  = v.em;
    pulse_mode = v.pm;
    term       = v.term;
    sb.push_back(v.exp);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    seq = 1'b0;
    en = 1'b1;
    clr = 1'b0;
    edge_mode = 1'b0;
    pulse_mode = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic run(input string nm, input vec_t v[$]);
    foreach (v[i]) begin
      apply(v[i]);
      ex  = sb.pop_front();
      got = sample();
      nvec++;
      if (got !== ex) begin
        $display("FAIL %s[%0d] got c=%0d d=%0b h=%0b w=%0d want c=%0d d=%0b h=%0b w=%0d",
                 nm, i, got.c, got.d, got.h, got.w, ex.c, ex.d, ex.h, ex.w);
        nmis++;
      end
    end
  endtask

  task automatic test_reset();
    term = 4'd0;
    rst = 1'b1;
    seq = 1'b1;
    en = 1'b1;
    clr = 1'b0;
    edge_mode = 1'b0;
    pulse_mode = 1'b0;
    #3;
    for (int k = 0; k < 2; k++) begin
      got = sample();
      nvec++;
      if (got !== '0) begin
        $display("FAIL reset[%0d] got %h want 0", k, got);
        nmis++;
      end
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    vec_t v[$];
    do_reset();
    v.push_back(mk(1,1,0,0,0,3, 1,0,0,0));
    v.push_back(mk(1,1,0,0,0,3, 2,0,0,0));
    v.push_back(mk(1,1,0,0,0,3, 3,1,0,0));
    v.push_back(mk(1,1,0,0,0,3, 0,0,1,1));
    v.push_back(mk(1,1,0,0,0,3, 1,0,0,1));
    v.push_back(mk(1,1,0,0,0,3, 2,0,0,1));
    v.push_back(mk(1,1,0,0,0,3, 3,1,0,1));
    v.push_back(mk(1,1,0,0,0,3, 0,0,1,2));
    v.push_back(mk(0,1,0,0,0,3, 0,0,0,2));
    run("basic", v);
  endtask

  task automatic test_edge();
    vec_t v[$];
    do_reset();
    for (int k = 0; k < 5; k++)
      v.push_back(mk(1,1,0,1,0,15, 1,0,0,0));
    v.push_back(mk(0,1,0,1,0,15, 1,0,0,0));
    v.push_back(mk(0,1,0,1,0,15, 1,0,0,0));
    v.push_back(mk(1,1,0,1,0,15, 2,0,0,0));
    v.push_back(mk(1,0,0,1,0,15, 2,0,0,0));
    run("edge", v);
  endtask

  task automatic test_pulse_hold();
    vec_t v[$];
    do_reset();
    v.push_back(mk(1,1,0,0,1,2, 1,0,0,0));
    v.push_back(mk(1,1,0,0,1,2, 2,1,0,0));
    for (int k = 0; k < 4; k++)
      v.push_back(mk(1,0,0,0,1,2, 2,0,0,0));
    v.push_back(mk(1,1,0,0,1,0, 0,1,1,1));
    v.push_back(mk(1,1,0,0,1,0, 0,1,1,2));
    run("pulse_hold", v);
  endtask

  task automatic test_term_low();
    vec_t v[$];
    do_reset();
    for (int k = 1; k <= 5; k++)
      v.push_back(mk(1,1,0,0,0,7, k,0,0,0));
    v.push_back(mk(0,1,0,0,0,3, 5,1,0,0));
    v.push_back(mk(1,1,0,0,0,3, 0,0,1,1));
    v.push_back(mk(1,1,0,0,0,0, 0,1,1,2));
    v.push_back(mk(1,1,0,0,0,0, 0,1,1,3));
    v.push_back(mk(1,1,0,0,0,0, 0,1,1,3));
    run("term_low", v);
  endtask

  task automatic test_clr_sat();
    vec_t v[$];
    do_reset();
    v.push_back(mk(1,1,0,0,0,0, 0,1,1,1));
    v.push_back(mk(1,1,0,0,0,0, 0,1,1,2));
    v.push_back(mk(1,1,0,0,0,0, 0,1,1,3));
    v.push_back(mk(1,1,0,0,0,0, 0,1,1,3));
    v.push_back(mk(1,1,0,0,0,0, 0,1,1,3));
    v.push_back(mk(1,1,1,0,1,0, 0,0,0,0));
    v.push_back(mk(1,1,0,0,0,5, 1,0,0,0));
    v.push_back(mk(1,1,0,0,0,5, 2,0,0,0));
    v.push_back(mk(1,1,1,0,0,5, 0,0,0,0));
    v.push_back(mk(1,1,1,0,0,0, 0,1,0,0));
    run("clr_sat", v);
  endtask

  task automatic test_back_to_back();
    vec_t v[$];
    do_reset();
    v.push_back(mk(1,1,0,1,0,0, 0,1,1,1));
    v.push_back(mk(1,1,0,1,0,0, 0,1,0,1));
    v.push_back(mk(0,1,0,1,0,0, 0,1,0,1));
    v.push_back(mk(1,1,0,1,0,0, 0,1,1,2));
    v.push_back(mk(1,1,0,1,1,0, 0,0,0,2));
    v.push_back(mk(0,1,0,1,1,0, 0,0,0,2));
    v.push_back(mk(1,1,0,1,1,0, 0,1,1,3));
    run("back_to_back", v);
  endtask

  task automatic test_async_reset();
    vec_t v[$];
    do_reset();
    v.push_back(mk(1,1,0,0,0,2, 1,0,0,0));
    v.push_back(mk(1,1,0,0,0,2, 2,1,0,0));
    v.push_back(mk(1,1,0,0,0,2, 0,0,1,1));
    v.push_back(mk(1,1,0,0,0,2, 1,0,0,1));
    v.push_back(mk(1,1,0,0,0,2, 2,1,0,1));
    run("async_pre", v);
    #2;
    rst = 1'b1;
    #1;
    got = sample();
    nvec++;
    if (got !== '0) begin
      $display("FAIL async_rst got %h want 0", got);
      nmis++;
    end
    edge_mode = 1'b1;
    #1;
    rst = 1'b0;
    v.delete();
    v.push_back(mk(1,1,0,1,0,2, 1,0,0,0));
    v.push_back(mk(1,1,0,1,0,2, 1,0,0,0));
    run("async_post", v);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_edge();
    test_pulse_hold();
    test_term_low();
    test_clr_sat();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
